// File: rtl/mor1kx_wb_ram_slave.sv
// Wishbone B3 RAM responder: classic and registered-feedback incrementing bursts, out-of-range -> ERR.
// Latency WAIT_STATES+1 to the first ACK/ERR, one beat per cycle inside a burst; the master throttles with STB.
module mor1kx_wb_ram_slave #(
    parameter int          MEM_WORDS_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          WAIT_STATES    = 0,
    parameter int          ENABLE_BURST   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int AW    = MEM_WORDS_LOG2 + 2;
    localparam int DEPTH = 1 << MEM_WORDS_LOG2;
    // The WAIT state is entered one cycle after the request, so it holds one count fewer.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SINGLE,
        S_BURST,
        S_ERR
    } state_t;

    state_t                    state_q, state_d, start_state;
    logic [3:0]                cnt_q, cnt_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [31:0]               dat_q, dat_d;
    logic                      req;
    logic                      burst_req;
    logic [31:0]               next_adr;
    logic [MEM_WORDS_LOG2-1:0] rd_idx;
    logic [MEM_WORDS_LOG2-1:0] wr_idx;
    logic                      wr_en;
    logic [31:0]               rd_word;
    logic [31:0]               mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return a[31:AW] == BASE_ADDR[31:AW];
    endfunction

    function automatic logic [31:0] next_beat_adr(input logic [31:0] a, input logic [1:0] bte);
        logic [31:0] mask;
        logic [31:0] base;
        logic [31:0] incr;
        case (bte)
            2'b01:   mask = 32'h0000_000F;
            2'b10:   mask = 32'h0000_001F;
            2'b11:   mask = 32'h0000_003F;
            default: mask = 32'hFFFF_FFFF;
        endcase
        base = {a[31:2], 2'b00};
        incr = base + 32'd4;
        return (base & ~mask) | (incr & mask);
    endfunction

    assign req       = wb_cyc_i & wb_stb_i;
    assign burst_req = (ENABLE_BURST != 0) && (wb_cti_i == 3'b010);
    assign next_adr  = next_beat_adr(wb_adr_i, wb_bte_i);

    always_comb begin
        if (!in_range(wb_adr_i)) begin
            start_state = S_ERR;
        end else if (burst_req) begin
            start_state = S_BURST;
        end else begin
            start_state = S_SINGLE;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_idx  = wb_adr_i[AW-1:2];
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = start_state;
                        ack_d   = (start_state != S_ERR);
                        err_d   = (start_state == S_ERR);
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = start_state;
                    ack_d   = (start_state != S_ERR);
                    err_d   = (start_state == S_ERR);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SINGLE: state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            S_BURST: begin
                // ACK is speculative for the next beat; a beat only completes when STB is also high.
                if (!req || wb_cti_i != 3'b010) begin
                    state_d = S_IDLE;
                end else if (!in_range(next_adr)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    ack_d  = 1'b1;
                    rd_idx = next_adr[AW-1:2];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en   = ack_q & req & wb_we_i & in_range(wb_adr_i);
        wr_idx  = wb_adr_i[AW-1:2];
        rd_word = mem[rd_idx];
        // Forward lanes being written this cycle so back-to-back beats see fresh data.
        for (int n = 0; n < 4; n++) begin
            if (wr_en && wb_sel_i[n] && (wr_idx == rd_idx)) begin
                rd_word[8*n +: 8] = wb_dat_i[8*n +: 8];
            end
        end
        dat_d = ack_d ? rd_word : dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int n = 0; n < 4; n++) begin
                if (wb_sel_i[n]) begin
                    mem[wr_idx][8*n +: 8] <= wb_dat_i[8*n +: 8];
                end
            end
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_mor1kx_wb_ram_slave.sv
// Bench for mor1kx_wb_ram_slave: two instances (0 and 3 wait states) share one bus model,
// selected by use_b; a word-array memory model supplies every expected read value.
module tb_mor1kx_wb_ram_slave;

    localparam int          L    = 8;
    localparam int          SIZE = 4 << L;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    bit          use_b;
    logic        cyc_a, cyc_b;
    logic [31:0] dat_a, dat_b, dat_o;
    logic        ack_a, ack_b, err_a, err_b, rty_a, rty_b, ack, err;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [2][256];
    bit          ref_vld [2][256];
    logic [31:0] beat_dat [16];

    always #5 clk = ~clk;

    assign cyc_a = cyc & ~use_b;
    assign cyc_b = cyc & use_b;
    assign dat_o = use_b ? dat_b : dat_a;
    assign ack   = use_b ? ack_b : ack_a;
    assign err   = use_b ? err_b : err_a;

    mor1kx_wb_ram_slave #(.MEM_WORDS_LOG2(L), .BASE_ADDR(BASE), .WAIT_STATES(0), .ENABLE_BURST(1)) u_a (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we),
        .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_a), .wb_ack_o(ack_a), .wb_err_o(err_a), .wb_rty_o(rty_a));

    mor1kx_wb_ram_slave #(.MEM_WORDS_LOG2(L), .BASE_ADDR(BASE), .WAIT_STATES(3), .ENABLE_BURST(1)) u_b (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we),
        .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_b), .wb_ack_o(ack_b), .wb_err_o(err_b), .wb_rty_o(rty_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2) % 256;
    endfunction

    // Next beat address from the burst rules: +4, or +4 modulo the wrap span within its aligned block.
    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] bt);
        logic [31:0] span;
        if (bt == 2'b00) return a + 32'd4;
        span = 32'd8 << bt;
        return a - (a % span) + (((a % span) + 32'd4) % span);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        i = widx(a);
        for (int n = 0; n < 4; n++) begin
            if (s[n]) ref_mem[use_b][i][8*n +: 8] = d[8*n +: 8];
        end
        ref_vld[use_b][i] = 1'b1;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; cti = 3'b000; bte = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic present(input logic [31:0] a, input logic [1:0] bt, input bit w, input bit last);
        adr = a; we = w; wdat = $urandom; sel = 4'hF; bte = bt;
        cti = last ? 3'b111 : 3'b010;
        cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic classic(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                           input bit hold, output logic [31:0] rd, output int lat,
                           output bit ack_seen, output bit err_seen);
        adr = a; we = w; wdat = d; sel = s; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        lat = 0; ack_seen = 1'b0; err_seen = 1'b0; rd = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (ack || err) begin
                ack_seen = ack; err_seen = err; rd = dat_o;
                break;
            end
        end
        if (ack_seen || err_seen) begin
            @(posedge clk); #1;
            if (ack_seen && w) model_write(a, d, s);
            chk("term_single_cycle", 64'({ack, err}), 64'd0);
            if (hold) begin
                @(posedge clk); #1;
                chk("held_stb_ack_low", 64'(ack), 64'd0);
            end
        end
        idle_bus();
    endtask

    task automatic burst(input logic [31:0] a0, input logic [1:0] bt, input int n, input bit w,
                         input int gap_after, output int nack, output bit err_seen, output int span);
        logic [31:0] a;
        int i, gap, cyc_n, first_c, last_c;
        bit pend, pend_err, done;
        a = a0; i = 0; gap = 0; cyc_n = 0; first_c = -1; last_c = -1;
        pend = 1'b0; pend_err = 1'b0; done = 1'b0; nack = 0; err_seen = 1'b0;
        present(a, bt, w, n == 1);
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
            cyc_n++;
            if (pend) begin
                if (w) model_write(a, wdat, 4'hF);
                nack++; i++; pend = 1'b0;
                if (i == n) begin
                    done = 1'b1;
                end else begin
                    a = nxt(a, bt);
                    if (i == gap_after) begin
                        stb = 1'b0;
                        gap = 2;
                    end else begin
                        present(a, bt, w, i == n - 1);
                    end
                end
            end else if (pend_err) begin
                err_seen = 1'b1;
                done = 1'b1;
            end else if (gap > 0) begin
                gap--;
                if (gap == 1) chk("burst_gap_ack_low", 64'(ack), 64'd0);
                else present(a, bt, w, i == n - 1);
            end
            if (!done && stb && ack) begin
                pend = 1'b1;
                if (first_c < 0) first_c = cyc_n;
                last_c = cyc_n;
                if (i < 16) beat_dat[i] = dat_o;
                if (!w) chk("burst_rd_data", 64'(dat_o), 64'(ref_mem[use_b][widx(a)]));
            end
            if (!done && stb && err) pend_err = 1'b1;
        end
        if (!done) chk("burst_timeout", 64'(i), 64'(n));
        else chk("burst_end_quiet", 64'({ack, err}), 64'd0);
        span = last_c - first_c;
        idle_bus();
    endtask

    always @(negedge clk) begin
        if (!rst) chk("ack_err_exclusive", 64'({ack_a & err_a, ack_b & err_b}), 64'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, nack, span, ws, w0, n, gapa;
        bit as, es, wr;
        logic [1:0] bt;
        logic [3:0] s;

        use_b = 1'b0; rst = 1'b1; adr = '0; wdat = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; cti = 3'b000; bte = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ack_a", 64'(ack_a), 64'd0);
        chk("rst_err_a", 64'(err_a), 64'd0);
        chk("rst_dat_a", 64'(dat_a), 64'd0);
        chk("rst_rty_a", 64'(rty_a), 64'd0);
        chk("rst_ack_b", 64'(ack_b), 64'd0);
        chk("rst_err_b", 64'(err_b), 64'd0);
        chk("rst_dat_b", 64'(dat_b), 64'd0);
        chk("rst_rty_b", 64'(rty_b), 64'd0);
        @(posedge clk); #1;

        // Zero wait states: write then read back.
        classic(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, lat, as, es);
        chk("t1_wr_lat", 64'(lat), 64'd1);
        chk("t1_wr_ack", 64'({as, es}), 64'b10);
        classic(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b0, rd, lat, as, es);
        chk("t1_rd_lat", 64'(lat), 64'd1);
        chk("t1_rd_dat", 64'(rd), 64'hDEAD_BEEF);

        // Byte lanes.
        classic(BASE + 32'h20, 1'b1, 32'h1122_3344, 4'hF, 1'b0, rd, lat, as, es);
        classic(BASE + 32'h20, 1'b1, 32'hAA00_0000, 4'h8, 1'b0, rd, lat, as, es);
        classic(BASE + 32'h20, 1'b0, 32'h0, 4'hF, 1'b0, rd, lat, as, es);
        chk("t3_lanes", 64'(rd), 64'hAA22_3344);

        // Wrap4 read burst from 0x18.
        for (int k = 0; k < 4; k++)
            classic(BASE + 32'h10 + 32'(4 * k), 1'b1, 32'hC0DE_0010 + 32'(4 * k), 4'hF, 1'b0, rd, lat, as, es);
        burst(BASE + 32'h18, 2'b01, 4, 1'b0, -1, nack, es, span);
        chk("t4_nack", 64'(nack), 64'd4);
        chk("t4_consecutive", 64'(span), 64'd3);
        chk("t4_beat0", 64'(beat_dat[0]), 64'hC0DE_0018);
        chk("t4_beat1", 64'(beat_dat[1]), 64'hC0DE_001C);
        chk("t4_beat2", 64'(beat_dat[2]), 64'hC0DE_0010);
        chk("t4_beat3", 64'(beat_dat[3]), 64'hC0DE_0014);

        // Linear write burst with an STB gap after three beats.
        burst(BASE + 32'h40, 2'b00, 8, 1'b1, 3, nack, es, span);
        chk("t5_nack", 64'(nack), 64'd8);
        for (int k = 0; k < 8; k++) begin
            classic(BASE + 32'h40 + 32'(4 * k), 1'b0, 32'h0, 4'hF, 1'b0, rd, lat, as, es);
            chk("t5_word", 64'(rd), 64'(ref_mem[0][widx(BASE + 32'h40 + 32'(4 * k))]));
        end

        // Out of range above and below the window.
        classic(BASE + SIZE, 1'b0, 32'h0, 4'hF, 1'b0, rd, lat, as, es);
        chk("t6_hi_err", 64'({as, es}), 64'b01);
        chk("t6_hi_lat", 64'(lat), 64'd1);
        classic(BASE - 32'd4, 1'b1, 32'h1234_5678, 4'hF, 1'b0, rd, lat, as, es);
        chk("t6_lo_err", 64'({as, es}), 64'b01);

        // Linear burst running off the top of RAM.
        burst(BASE + SIZE - 32'd8, 2'b00, 4, 1'b1, -1, nack, es, span);
        chk("t6_top_nack", 64'(nack), 64'd2);
        chk("t6_top_err", 64'(es), 64'd1);
        for (int k = 0; k < 2; k++) begin
            classic(BASE + SIZE - 32'd8 + 32'(4 * k), 1'b0, 32'h0, 4'hF, 1'b0, rd, lat, as, es);
            chk("t6_top_word", 64'(rd), 64'(ref_mem[0][widx(BASE + SIZE - 32'd8 + 32'(4 * k))]));
        end

        // Reset in the middle of a burst.
        present(BASE + 32'h40, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t6_rst_pre_ack", 64'(ack), 64'd1);
        adr = BASE + 32'h44; rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_quiet", 64'({ack, err}), 64'd0);
        rst = 1'b0;
        idle_bus();

        // Three wait states: latency and held STB.
        use_b = 1'b1;
        classic(BASE + 32'h30, 1'b1, 32'h5A5A_0F0F, 4'hF, 1'b0, rd, lat, as, es);
        chk("t2_wr_lat", 64'(lat), 64'd4);
        classic(BASE + 32'h30, 1'b0, 32'h0, 4'hF, 1'b1, rd, lat, as, es);
        chk("t2_rd_lat", 64'(lat), 64'd4);
        chk("t2_rd_dat", 64'(rd), 64'h5A5A_0F0F);
        classic(BASE + SIZE + 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, rd, lat, as, es);
        chk("t2_err_lat", 64'(lat), 64'd4);
        chk("t2_err_only", 64'({as, es}), 64'b01);

        // Random traffic on both instances.
        for (int inst = 0; inst < 2; inst++) begin
            use_b = (inst == 1);
            ws = use_b ? 3 : 0;
            for (int op = 0; op < 30; op++) begin
                case ($urandom_range(0, 2))
                    0, 1: begin
                        w0 = $urandom_range(0, 255);
                        wr = !ref_vld[use_b][w0] || ($urandom_range(0, 1) == 1);
                        s = ref_vld[use_b][w0] ? 4'($urandom_range(1, 15)) : 4'hF;
                        classic(BASE + 32'(4 * w0), wr, $urandom, s, 1'b0, rd, lat, as, es);
                        chk("rnd_lat", 64'(lat), 64'(ws + 1));
                        if (!wr) chk("rnd_rd", 64'(rd), 64'(ref_mem[use_b][w0]));
                    end
                    default: begin
                        bt = 2'($urandom_range(0, 3));
                        n = $urandom_range(1, 8);
                        w0 = (bt == 2'b00) ? $urandom_range(0, 256 - n) : $urandom_range(0, 255);
                        gapa = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
                        burst(BASE + 32'(4 * w0), bt, n, 1'b1, gapa, nack, es, span);
                        chk("rnd_wr_nack", 64'(nack), 64'(n));
                        burst(BASE + 32'(4 * w0), bt, n, 1'b0, -1, nack, es, span);
                        chk("rnd_rd_nack", 64'(nack), 64'(n));
                    end
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
